// File: rtl/bp_sched_if.sv
// Scheduler command/status bundle between the decoder controller and the
// BP stage scheduler, plus the PE issue strobes it produces.
interface bp_sched_if #(
  parameter int LOG_N  = 10,
  parameter int LOG_P  = 4,
  parameter int ITER_W = 6,
  parameter int STG_W  = 4
);
  localparam int GW = LOG_N - 1 - LOG_P;

  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              early_stop;
  logic              pe_stall;

  logic              busy;
  logic              pe_valid;
  logic              pe_dir;
  logic [STG_W-1:0]  pe_stage;
  logic [GW-1:0]     pe_group;
  logic [ITER_W-1:0] iter;
  logic              last_iter;
  logic              done;
  logic [ITER_W-1:0] iters_used;

  modport master (
    output start, max_iter, early_stop, pe_stall,
    input  busy, pe_valid, pe_dir, pe_stage, pe_group, iter, last_iter, done, iters_used
  );

  modport slave (
    input  start, max_iter, early_stop, pe_stall,
    output busy, pe_valid, pe_dir, pe_stage, pe_group, iter, last_iter, done, iters_used
  );
endinterface

// File: rtl/bp_sched.sv
// Iteration/stage scheduler for the BP polar decoder PE array: L sweep down,
// R sweep up, grouped butterfly issue with a PE drain between stages.
module bp_sched #(
  parameter int LOG_N  = 10,
  parameter int LOG_P  = 4,
  parameter int PE_LAT = 2,
  parameter int ITER_W = 6,
  parameter int STG_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  bp_sched_if.slave  bus
);
  localparam int GW = LOG_N - 1 - LOG_P;
  localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [STG_W-1:0] STAGE_TOP  = STG_W'(LOG_N - 1);
  localparam logic [GW-1:0]    GROUP_LAST = '1;
  localparam logic [DW-1:0]    DRAIN_INIT = DW'((PE_LAT > 0) ? PE_LAT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CHECK, S_DONE} state_t;

  state_t            state;
  logic              busy, pe_dir, done;
  logic [STG_W-1:0]  pe_stage;
  logic [GW-1:0]     pe_group;
  logic [ITER_W-1:0] iter, iters_used, max_eff;
  logic [DW-1:0]     drain_cnt;

  logic              nxt_dir, sweep_end, stage_done;
  logic [STG_W-1:0]  nxt_stage;
  logic [ITER_W:0]   iter_inc;

  assign iter_inc   = {1'b0, iter} + 1'b1;
  assign stage_done = (state == S_DRAIN && drain_cnt == '0) ||
                      (PE_LAT == 0 && state == S_ISSUE && !bus.pe_stall && pe_group == GROUP_LAST);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_dir   = pe_dir;
    nxt_stage = pe_stage;
    sweep_end = 1'b0;
    if (!pe_dir) begin
      if (pe_stage == '0) nxt_dir   = 1'b1;
      else                nxt_stage = pe_stage - 1'b1;
    end else begin
      if (pe_stage == STAGE_TOP) sweep_end = 1'b1;
      else                       nxt_stage = pe_stage + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      pe_dir     <= 1'b0;
      pe_stage   <= '0;
      pe_group   <= '0;
      iter       <= '0;
      done       <= 1'b0;
      iters_used <= '0;
      max_eff    <= '0;
      drain_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            max_eff  <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
            iter     <= '0;
            busy     <= 1'b1;
            pe_dir   <= 1'b0;
            pe_stage <= STAGE_TOP;
            pe_group <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus.pe_stall) begin
            if (pe_group == GROUP_LAST) begin
              pe_group <= '0;
              if (PE_LAT != 0) begin
                drain_cnt <= DRAIN_INIT;
                state     <= S_DRAIN;
              end
            end else begin
              pe_group <= pe_group + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        end
        S_CHECK: begin
          iter <= iter_inc[ITER_W-1:0];
          if (bus.early_stop || iter_inc >= {1'b0, max_eff}) begin
            done       <= 1'b1;
            iters_used <= iter_inc[ITER_W-1:0];
            state      <= S_DONE;
          end else begin
            pe_dir   <= 1'b0;
            pe_stage <= STAGE_TOP;
            state    <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy     <= 1'b0;
          pe_dir   <= 1'b0;
          pe_stage <= '0;
          pe_group <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Shared stage-advance decision, reached from DRAIN or straight from ISSUE when PE_LAT is 0.
      if (stage_done) begin
        if (sweep_end) begin
          state <= S_CHECK;
        end else begin
          pe_dir   <= nxt_dir;
          pe_stage <= nxt_stage;
          state    <= S_ISSUE;
        end
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.pe_valid   = (state == S_ISSUE) && !bus.pe_stall;
  assign bus.pe_dir     = pe_dir;
  assign bus.pe_stage   = pe_stage;
  assign bus.pe_group   = pe_group;
  assign bus.iter       = iter;
  assign bus.last_iter  = busy && (iter == max_eff - 1'b1);
  assign bus.done       = done;
  assign bus.iters_used = iters_used;
endmodule

// File: doc/bp_sched.md
Name: bp_sched

Overview:
- Iteration/stage scheduler for the BP polar decoder PE array.
- For one codeword, sequences the PE array through the factor graph: a left-message (L) sweep from stage LOG_N-1 down to 0, then a right-message (R) sweep from stage 0 up to LOG_N-1.
- Each stage is issued in groups of 2^LOG_P butterflies, with a pipeline drain between stages.
- After each iteration, samples the early-termination check and either starts another iteration or signals completion.

Parameters:
- LOG_N, 10, log2 code length N.
- LOG_P, 4, log2 of PE count. Requires LOG_P <= LOG_N-1.
- PE_LAT, 2, PE pipeline latency in cycles. Sets the drain length between stages; 0 allowed.
- ITER_W, 6, iteration counter width.
- STG_W, 4, stage index width. Requires 2^STG_W >= LOG_N.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin decode. Sampled only in IDLE.
- max_iter  in  ITER_W  iteration limit. Latched on accepted start; 0 is treated as 1.
- early_stop  in  1  early-termination flag from check unit. Sampled only in CHECK.
- pe_stall  in  1  backpressure from memory/PE path.
- busy  out  1  high from the cycle after accepted start through the DONE cycle.
- pe_valid  out  1  PE issue strobe for the current stage/group.
- pe_dir  out  1  0 = L sweep, 1 = R sweep.
- pe_stage  out  STG_W  current stage index.
- pe_group  out  LOG_N-1-LOG_P  current butterfly group, 0..G-1, where G = 2^(LOG_N-1-LOG_P).
- iter  out  ITER_W  completed iterations in the current run.
- last_iter  out  1  busy && iter == max_iter_eff-1.
- done  out  1  one-cycle completion pulse.
- iters_used  out  ITER_W  iterations consumed by the last run. Updated at done; held until the next done.

Behaviour:
- Reset (async, immediate): state IDLE; all registered outputs 0 (busy, pe_dir, pe_stage, pe_group, iter, done, iters_used); the drain counter is cleared. Because pe_valid is qualified by state, it is also 0.
- States: IDLE, ISSUE, DRAIN, CHECK, DONE.
- IDLE: pe_stage = 0, pe_group = 0, pe_dir = 0.
  - On start = 1, latch max_iter_eff = (max_iter == 0 ? 1 : max_iter), clear iter, and go to ISSUE with pe_dir = 0, pe_stage = LOG_N-1, pe_group = 0.
- ISSUE: pe_valid = !pe_stall (combinational).
  - Stalled cycle: pe_group and pe_stage hold.
  - Unstalled cycle with pe_group < G-1: pe_group increments.
  - Unstalled cycle with pe_group == G-1: pe_group returns to 0 and the state goes to DRAIN (or directly to the next-stage decision if PE_LAT == 0).
- DRAIN: pe_valid = 0 for exactly PE_LAT cycles. pe_stall is ignored. Then the next-stage decision is taken:
  - L sweep, pe_stage > 0: pe_stage decrements; go to ISSUE.
  - L sweep, pe_stage == 0: pe_dir = 1, pe_stage stays 0; go to ISSUE. This begins the R sweep at stage 0.
  - R sweep, pe_stage < LOG_N-1: pe_stage increments; go to ISSUE.
  - R sweep, pe_stage == LOG_N-1: go to CHECK.
- CHECK (1 cycle): iter <= iter+1.
  - If early_stop || iter+1 >= max_iter_eff: go to DONE.
  - Otherwise: pe_dir = 0, pe_stage = LOG_N-1; go to ISSUE.
- DONE (1 cycle): done = 1, iters_used = iter, busy still 1. Next cycle: IDLE, busy = 0.
- start while not in IDLE: ignored.
- max_iter changes mid-run: no effect.
- Unstalled per-iteration latency: 2·LOG_N·(G+PE_LAT) + 1 cycles.
- Run latency (start edge to done): iterations × per-iteration latency + 1 cycle.

Test Plan:
All scenarios use LOG_N=3, LOG_P=1, PE_LAT=2, giving G=2 and 25 cycles per iteration. Cycle 0 is the edge that samples start.
1. start, max_iter=1, early_stop=0, no stall -> (stage, dir) sequence is (2,0), (1,0), (0,0), (0,1), (1,1), (2,1). Each stage shows pe_valid high for 2 cycles (groups 0,1) then low for 2. done pulses in cycle 26; iters_used=1; busy low in cycle 27.
2. max_iter=3, early_stop=0 -> done in cycle 76; iters_used=3; last_iter high during the third iteration only.
3. max_iter=5, early_stop=1 only during the second CHECK -> done in cycle 51; iters_used=2.
4. max_iter=1, pe_stall high for 3 cycles starting on stage-1 group-1 of the L sweep -> pe_valid low for those cycles, pe_group held at 1; done in cycle 29.
5. rst pulsed during the R sweep -> all outputs 0 in the same cycle. A following start with max_iter=1 completes in 26 cycles.
6. max_iter=0 -> behaves as 1 (done in cycle 26). A second start pulsed while busy is ignored: exactly one done pulse.
